// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types, frame constants and frame-bit helpers for the PS/2 device transmitter
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    LOW   = 2'd2,
    GAP   = 2'd3
  } state_e;

  localparam int FRAME_BITS = 11;

  // Parity bit that makes data+parity contain an odd number of ones
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

  function automatic logic frame_bit(input logic [7:0] data, input logic [3:0] idx);
    logic [2:0] sel;
    sel = 3'(idx - 4'd1);
    if (idx == 4'd0) begin
      return 1'b0;
    end else if (idx <= 4'd8) begin
      return data[sel];
    end else if (idx == 4'd9) begin
      return odd_parity(data);
    end else begin
      return 1'b1;
    end
  endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// rtl/ps2_sync_fifo.sv - single-clock FIFO with full/empty flags for queued scancodes
module ps2_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
    $error("ps2_sync_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ps2_dev_tx.sv
// rtl/ps2_dev_tx.sv - buffered PS/2 device transmitter; define PS2_INHIBIT_EN for host clock-inhibit support
module ps2_dev_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int PS2_HZ     = 12_500,
  parameter int FIFO_DEPTH = 8,
  parameter int GAP_BITS   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       overflow,
  input  logic       ps2_clk_i,
  output logic       ps2_clk_o,
  output logic       ps2_data_o,
  output logic       busy
);

  localparam int HALF    = CLK_HZ / (2 * PS2_HZ);
  localparam int PW      = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int GAP_PH  = 2 * GAP_BITS;
  localparam int BIT_MAX = (GAP_PH > FRAME_BITS) ? GAP_PH : FRAME_BITS;
  localparam int BW      = $clog2(BIT_MAX);

  localparam logic [PW-1:0] PH_LOAD  = PW'(HALF - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);
  localparam logic [BW-1:0] LAST_GAP = BW'(GAP_PH - 1);

  if (HALF < 2) begin : g_half_chk
    $error("ps2_dev_tx: CLK_HZ/(2*PS2_HZ) must be at least 2");
  end

  state_e        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          clk_q, clk_d;
  logic          data_q, data_d;

  logic          fifo_push;
  logic          fifo_pop;
  logic [7:0]    fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic          inhibit;
  logic          cur_bit;

  assign in_ready   = !fifo_full;
  assign overflow   = in_valid && !in_ready;
  assign fifo_push  = in_valid && in_ready;
  assign busy       = (state_q != IDLE) || !fifo_empty;
  assign ps2_clk_o  = clk_q;
  assign ps2_data_o = data_q;
  assign cur_bit    = frame_bit(shreg_q, 4'(bit_q));

  ps2_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (in_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef PS2_INHIBIT_EN
  logic [1:0] clk_sync_q;

  always_ff @(posedge clk) begin
    if (rst) clk_sync_q <= 2'b11;
    else     clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
  end

  // Host pulls the clock low while we release it high
  assign inhibit = !clk_sync_q[1] && clk_q;
`else
  logic unused_ps2_clk_i;
  assign unused_ps2_clk_i = ps2_clk_i;
  assign inhibit          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      clk_q   <= 1'b1;
      data_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      clk_q   <= clk_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && !inhibit) begin
          state_d = SETUP;
          phase_d = PH_LOAD;
          bit_d   = '0;
          shreg_d = fifo_rdata;
        end
      end
      SETUP: begin
        if (inhibit && (bit_q != LAST_BIT)) begin
          state_d = (GAP_BITS == 0) ? IDLE : GAP;
          phase_d = PH_LOAD;
          bit_d   = '0;
        end else if (phase_q == '0) begin
          state_d = LOW;
          phase_d = PH_LOAD;
        end else begin
          phase_d = phase_q - PW'(1);
        end
      end
      LOW: begin
        if (phase_q == '0) begin
          phase_d = PH_LOAD;
          if (bit_q == LAST_BIT) begin
            fifo_pop = 1'b1;
            state_d  = (GAP_BITS == 0) ? IDLE : GAP;
            bit_d    = '0;
          end else begin
            state_d = SETUP;
            bit_d   = bit_q + BW'(1);
          end
        end else begin
          phase_d = phase_q - PW'(1);
        end
      end
      GAP: begin
        if (!inhibit) begin
          if (phase_q != '0) begin
            phase_d = phase_q - PW'(1);
          end else if (bit_q != LAST_GAP) begin
            phase_d = PH_LOAD;
            bit_d   = bit_q + BW'(1);
          end else if (!fifo_empty) begin
            // Skip IDLE so back-to-back frames are separated by exactly the gap
            state_d = SETUP;
            phase_d = PH_LOAD;
            bit_d   = '0;
            shreg_d = fifo_rdata;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    clk_d  = 1'b1;
    data_d = 1'b1;
    case (state_q)
      SETUP:   data_d = (inhibit && (bit_q != LAST_BIT)) ? 1'b1 : cur_bit;
      LOW: begin
        clk_d  = 1'b0;
        data_d = cur_bit;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ps2_dev_tx.sv
// tb/tb_ps2_dev_tx.sv - directed scoreboard bench for ps2_dev_tx (HALF=5, GAP_BITS=2)
module tb_ps2_dev_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       overflow;
  logic       ps2_clk_i = 1'b1;
  logic       ps2_clk_o;
  logic       ps2_data_o;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [7:0]  expq[$];
  int          start_q[$];
  int          end_q[$];
  logic [10:0] bits_log[$];

  logic [10:0] fbits = '0;
  int          bitcnt = 0;
  int          frame_cnt = 0;
  int          fall_cnt = 0;
  int          hi_cnt = 0;
  logic        pend = 1'b0;
  logic        prev_c = 1'b1;
  logic        prev_d = 1'b1;

  ps2_dev_tx #(
    .CLK_HZ     (1000),
    .PS2_HZ     (100),
    .FIFO_DEPTH (8),
    .GAP_BITS   (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .overflow   (overflow),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_clk_o  (ps2_clk_o),
    .ps2_data_o (ps2_data_o),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line monitor: decodes frames on falling PS/2 clock edges and checks them against the scoreboard
  always @(negedge clk) begin
    logic       c, d;
    logic [7:0] rx, exp;
    c = ps2_clk_o;
    d = ps2_data_o;
    if (c === 1'b1 && prev_c === 1'b0 && pend) begin
      pend = 1'b0;
      end_q.push_back(cyc);
      bits_log.push_back(fbits);
      frame_cnt++;
      rx = fbits[8:1];
      check("start_bit", fbits[0], 0);
      check("stop_bit", fbits[10], 1);
      check("parity_bit", fbits[9], ~^rx);
      check("frame_expected", expq.size() > 0, 1);
      if (expq.size() > 0) begin
        exp = expq.pop_front();
        check("frame_byte", rx, exp);
      end
    end
    if (c === 1'b0 && prev_c === 1'b1) begin
      fbits[bitcnt] = d;
      fall_cnt++;
      bitcnt++;
      if (bitcnt == 11) begin
        pend   = 1'b1;
        bitcnt = 0;
      end
    end
    if (d === 1'b0 && prev_d === 1'b1 && c === 1'b1 && bitcnt == 0 && !pend) start_q.push_back(cyc);
    if (c === 1'b1) hi_cnt++;
    else            hi_cnt = 0;
    if (hi_cnt > 10 && bitcnt != 0) bitcnt = 0;
    prev_c = c;
    prev_d = d;
  end

  task automatic wait_frames(input int target, input int budget, input string tag);
    int n = 0;
    while (frame_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, frame_cnt >= target, 1);
  endtask

  task automatic clear_logs();
    start_q.delete();
    end_q.delete();
    bits_log.delete();
  endtask

  initial begin
    int push_cyc, f0, fc0, n;
    logic [7:0] b;

    // Reset and idle
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    check("idle_clk", ps2_clk_o, 1);
    check("idle_data", ps2_data_o, 1);
    check("idle_busy", busy, 0);
    check("idle_ready", in_ready, 1);
    check("idle_overflow", overflow, 0);

    // Single byte 0x1C: bits, latency and frame length
    clear_logs();
    @(negedge clk);
    in_data  = 8'h1C;
    in_valid = 1'b1;
    expq.push_back(8'h1C);
    @(negedge clk);
    in_valid = 1'b0;
    push_cyc = cyc;
    check("busy_after_push", busy, 1);
    wait_frames(1, 300, "frame_1c_timeout");
    check("bits_1c", bits_log[0], 11'h438);
    check("latency_1c", start_q[0] - push_cyc, 2);
    check("length_1c", end_q[0] - start_q[0], 110);
    repeat (30) @(negedge clk);
    check("busy_after_1c", busy, 0);

    // Two back-to-back bytes: parity and inter-frame gap
    clear_logs();
    f0 = frame_cnt;
    @(negedge clk);
    in_data  = 8'hF0;
    in_valid = 1'b1;
    expq.push_back(8'hF0);
    @(negedge clk);
    in_data  = 8'h1C;
    expq.push_back(8'h1C);
    @(negedge clk);
    in_valid = 1'b0;
    wait_frames(f0 + 2, 400, "frame_pair_timeout");
    check("bits_f0", bits_log[0], 11'h7E0);
    check("parity_f0", bits_log[0][9], 1);
    check("gap_f0_1c", start_q[1] - end_q[0], 20);
    check("length_2nd", end_q[1] - start_q[1], 110);
    repeat (30) @(negedge clk);

    // Nine pushes into an eight-entry FIFO
    f0 = frame_cnt;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      b        = 8'(i * 29 + 3);
      in_data  = b;
      in_valid = 1'b1;
      if (i < 8) expq.push_back(b);
      #1;
      check("burst_overflow", overflow, (i == 8) ? 1 : 0);
      if (i == 8) check("burst_ready_full", in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    wait_frames(f0 + 8, 1500, "burst_timeout");
    repeat (200) @(negedge clk);
    check("burst_frame_count", frame_cnt - f0, 8);
    check("burst_busy_end", busy, 0);

    // Reset in the middle of bit 5 with three bytes queued
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_data  = 8'h5A + 8'(i);
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (bitcnt != 5 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("reach_bit5", bitcnt, 5);
    rst = 1'b1;
    @(negedge clk);
    check("rst_clk_high", ps2_clk_o, 1);
    check("rst_data_high", ps2_data_o, 1);
    check("rst_busy", busy, 0);
    check("rst_ready", in_ready, 1);
    rst = 1'b0;
    f0  = frame_cnt;
    fc0 = fall_cnt;
    repeat (400) @(negedge clk);
    check("rst_no_frames", frame_cnt, f0);
    check("rst_no_clock", fall_cnt, fc0);
    check("rst_busy_later", busy, 0);

`ifdef PS2_INHIBIT_EN
    // Host inhibit during bit 4 setup aborts and retransmits the byte
    clear_logs();
    f0 = frame_cnt;
    @(negedge clk);
    in_data  = 8'hA5;
    in_valid = 1'b1;
    expq.push_back(8'hA5);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!(bitcnt == 4 && ps2_clk_o === 1'b1) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("reach_bit4", bitcnt, 4);
    ps2_clk_i = 1'b0;
    fc0 = fall_cnt;
    repeat (4) @(negedge clk);
    check("inh_clk_high", ps2_clk_o, 1);
    check("inh_data_high", ps2_data_o, 1);
    repeat (26) @(negedge clk);
    ps2_clk_i = 1'b1;
    check("inh_no_clock", fall_cnt, fc0);
    check("inh_no_frame", frame_cnt, f0);
    wait_frames(f0 + 1, 400, "inh_retx_timeout");
    check("bits_a5", bits_log[0], 11'h74A);
    repeat (30) @(negedge clk);
`endif

    check("scoreboard_drained", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ps2_dev_tx.md
Name: ps2_dev_tx

Overview:
- Parametrised PS/2 device-side transmitter; successor to the single-byte PS/2 sender in the UART-to-PS/2 bridge.
- Buffers scancodes in an internal FIFO and frames each byte as 11-bit PS/2: start, 8 data LSB-first, odd parity, stop.
- Generates PS/2 clock from a parametrised system clock, with inter-frame gap and overflow reporting.
- Sits between the ASCII-to-scancode converter and the PS/2 pins.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency.
- PS2_HZ, 12_500, PS/2 bit rate; HALF = CLK_HZ/(2*PS2_HZ) cycles per clock phase; elaboration error if HALF < 2.
- FIFO_DEPTH, 8, scancode buffer entries; power of two, >= 2.
- GAP_BITS, 2, idle bit-times (2*HALF cycles each) with both lines high between frames.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- in_data  in  8  scancode byte.
- in_valid  in  1  push strobe; single-cycle pulses allowed.
- in_ready  out  1  FIFO not full.
- overflow  out  1  one-cycle pulse when in_valid && !in_ready; byte dropped.
- ps2_clk_i  in  1  sensed PS/2 clock line (used only with PS2_INHIBIT_EN).
- ps2_clk_o  out  1  PS/2 clock level, idle 1.
- ps2_data_o  out  1  PS/2 data level, idle 1.
- busy  out  1  frame or gap in progress, or FIFO non-empty.

Behaviour:
- Reset values: ps2_clk_o=1, ps2_data_o=1, busy=0, overflow=0, in_ready=1, FIFO empty, state IDLE, counters 0.
- Reset mid-frame: lines high on the cycle after the reset edge; FIFO flushed; the partial frame is lost.
- FIFO:
  - Push on in_valid && in_ready.
  - Pop at the end of a frame's stop-bit LOW phase.
  - Push and pop in the same cycle when full: the pop frees the slot, but in_ready is registered from the prior state, so the push is dropped and overflow pulses.
  - Push and pop on the same cycle when not full: both are performed.
- States:
  - IDLE: lines high. FIFO non-empty -> SETUP with bit=0; the head byte is latched into the shift register and parity computed.
  - SETUP: ps2_clk_o=1, ps2_data_o = frame bit[bit]. Lasts HALF cycles -> LOW.
  - LOW: ps2_clk_o=0, data held. Lasts HALF cycles. Then bit<10 -> bit+1, SETUP; bit==10 -> pop, GAP.
  - GAP: lines high for GAP_BITS*2*HALF cycles -> IDLE. If GAP_BITS==0, go directly to IDLE.
- Frame bits: [0]=0, [1..8]=byte[0..7], [9]=~^byte (odd parity over data+parity), [10]=1.
- Latency: byte accepted at edge N -> ps2_data_o=0 visible after edge N+2 when IDLE and FIFO was empty.
- Frame time: 22*HALF cycles. Back-to-back frames are separated by exactly the gap.
- Data changes only on entry to SETUP, never while ps2_clk_o=0.
- A phase counter counts HALF-1 down to 0. Its width is $clog2(HALF).
- busy=1 from the cycle after a push until GAP ends with FIFO empty.

Optional Feature:
- Macro: PS2_INHIBIT_EN.
- With the macro:
  - ps2_clk_i goes through a 2-FF synchroniser.
  - The line is inhibited when the synchronised ps2_clk_i=0 while ps2_clk_o=1.
  - In IDLE/GAP, inhibit holds the state; a frame does not start until the line is released.
  - In SETUP with bit<10, inhibit aborts: lines released high the next cycle, head byte not popped, -> GAP. The full frame is retransmitted afterwards.
  - Inhibit during the stop bit is ignored.
- Without the macro: ps2_clk_i is unused and the port remains for pin compatibility.

Decomposition:
- Package ps2_pkg:
  - state enum (IDLE, SETUP, LOW, GAP);
  - FRAME_BITS=11;
  - function frame_bit(byte, idx);
  - odd-parity function.
- One sub-module: ps2_sync_fifo, parametrised DEPTH and WIDTH, with full/empty/push/pop.

Test Plan:
All tests use CLK_HZ=1000, PS2_HZ=100 (HALF=5), GAP_BITS=2.
- Reset then idle 50 cycles -> ps2_clk_o=1, ps2_data_o=1, busy=0, in_ready=1.
- Push 0x1C -> data sampled at each ps2_clk_o falling edge = 0,0,0,1,1,1,0,0,0,0,1. Frame is 110 cycles and first start bit appears 2 cycles after the push.
- Push 0xF0 then 0x1C on consecutive cycles:
  - two frames, second start bit exactly 20 cycles after the first frame's last LOW phase ends;
  - 0xF0 parity bit = 1.
- Push 9 bytes back-to-back with FIFO_DEPTH=8 and the first frame not yet popped -> in_ready=0 after 8 pushes, overflow pulses once, 8 frames transmitted.
- Assert rst during bit 5 of a frame with 3 bytes queued -> lines high next cycle, busy=0, no further frames.
- With PS2_INHIBIT_EN, drive ps2_clk_i=0 for 30 cycles during bit 4 SETUP -> abort, lines high, then after release the same byte is retransmitted in full.
